// File: rtl/gray_codec_pkg.sv
// Shared types and helper functions for the pipelined Gray/binary codec.
//
// Contents:
//   codec_mode_e    per-word conversion mode (GRAY2BIN / BIN2GRAY)
//   MAX_W           widest word the helpers handle; codec WIDTH must not exceed it
//   chunk_size()    bits of the Gray prefix-XOR resolved per pipeline stage
//   bin2gray()      binary -> Gray conversion
//   gray2bin_chunk() resolves one MSB-first slice of the Gray -> binary prefix XOR
//   popcount()      number of set bits, used by the step checker
package gray_codec_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        GRAY2BIN = 1'b0,
        BIN2GRAY = 1'b1
    } codec_mode_e;

    function automatic int chunk_size(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Fills bits hi..lo of the partial binary result. 'carry' is the binary
    // bit just above hi (0 for the MSB slice); bits outside the slice are
    // returned unchanged from 'partial'. An empty slice (hi < lo) is a no-op.
    function automatic logic [MAX_W-1:0] gray2bin_chunk(
        input logic [MAX_W-1:0] g,
        input logic [MAX_W-1:0] partial,
        input logic             carry,
        input int               hi,
        input int               lo
    );
        logic [MAX_W-1:0] r;
        logic             c;
        r = partial;
        c = carry;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                c    = c ^ g[i];
                r[i] = c;
            end
        end
        return r;
    endfunction

    function automatic int popcount(input logic [MAX_W-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One register slice of the Gray/binary codec pipeline.
//
// Holds a word together with its partially resolved result, the carried
// binary bit at the bottom of the slice resolved so far, its mode and its
// step-error flag. Stage STAGE_IDX resolves Gray slice STAGE_IDX for
// GRAY2BIN words; stage 0 alone performs the BIN2GRAY conversion.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   up_valid / up_ready          handshake with the previous stage (or codec input)
//   up_word/res/carry/mode/err   payload from the previous stage
//   dn_ready                     load condition of the next stage (or out_ready)
//   dn_valid                     this stage holds a word
//   dn_word/res/carry/mode/err   registered payload towards the next stage
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 2,
    parameter int STAGE_IDX = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_word,
    input  logic [WIDTH-1:0] up_res,
    input  logic             up_carry,
    input  codec_mode_e      up_mode,
    input  logic             up_err,
    input  logic             dn_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_word,
    output logic [WIDTH-1:0] dn_res,
    output logic             dn_carry,
    output codec_mode_e      dn_mode,
    output logic             dn_err
);

    localparam int CHUNK_W = chunk_size(WIDTH, STAGES);
    localparam int HI      = WIDTH - 1 - STAGE_IDX * CHUNK_W;
    localparam int LO      = (HI - CHUNK_W + 1 > 0) ? (HI - CHUNK_W + 1) : 0;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             carry_q, carry_d;
    codec_mode_e      mode_q,  mode_d;
    logic             err_q,   err_d;
    logic             load;

    // A stage may take a new word when it is empty or its current word is
    // leaving this same cycle; this is what chains ready back to the input.
    always_comb begin
        load    = !valid_q || dn_ready;
        valid_d = valid_q;
        word_d  = word_q;
        res_d   = res_q;
        carry_d = carry_q;
        mode_d  = mode_q;
        err_d   = err_q;
        if (load) begin
            valid_d = up_valid;
            word_d  = up_word;
            res_d   = up_res;
            carry_d = up_carry;
            mode_d  = up_mode;
            err_d   = up_err;
            if (up_mode == GRAY2BIN) begin
                // With short trailing slices, late stages may have nothing left to resolve.
                if (HI >= 0) begin
                    res_d   = WIDTH'(gray2bin_chunk(MAX_W'(up_word), MAX_W'(up_res),
                                                    up_carry, HI, LO));
                    carry_d = res_d[LO];
                end
            end else if (STAGE_IDX == 0) begin
                res_d = WIDTH'(bin2gray(MAX_W'(up_word)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            mode_q  <= GRAY2BIN;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            word_q  <= word_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    assign up_ready = load;
    assign dn_valid = valid_q;
    assign dn_word  = word_q;
    assign dn_res   = res_q;
    assign dn_carry = carry_q;
    assign dn_mode  = mode_q;
    assign dn_err   = err_q;

endmodule

// File: rtl/gray_pipe_codec.sv
// Pipelined Gray/binary codec with valid/ready handshake and Gray step check.
//
// Each word is converted according to its own mode: GRAY2BIN decodes a Gray
// word across STAGES slices, BIN2GRAY encodes in the first stage and then just
// travels with the same latency. Accepted Gray (mode 0) words are compared
// with the previous accepted Gray word; a change of more than one bit flags
// the word, the flag rides along with it, and delivered flagged words are
// counted in a saturating counter.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (drops in-flight words)
//   in_valid        input word valid
//   in_ready        codec can accept a word this cycle
//   in_data         Gray (mode 0) or binary (mode 1) word
//   in_mode         0 = gray->bin, 1 = bin->gray
//   out_valid       result valid
//   out_ready       downstream accepts the result
//   out_data        converted word
//   out_mode        in_mode of the delivered word
//   out_step_err    delivered word was an illegal Gray step
//   err_count       saturating count of delivered illegal-step words
module gray_pipe_codec
    import gray_codec_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             out_step_err,
    output logic [CNT_W-1:0] err_count
);

    // Index k is the input side of stage k; index STAGES is the codec output.
    logic [STAGES:0] stg_valid;
    logic [STAGES:0] stg_ready;
    logic [STAGES:0] stg_err;
    logic            stg_carry [0:STAGES];
    logic [WIDTH-1:0] stg_word [0:STAGES];
    logic [WIDTH-1:0] stg_res  [0:STAGES];
    codec_mode_e      stg_mode [0:STAGES];

    logic [WIDTH-1:0] hist_q, hist_d;
    logic             hist_valid_q, hist_valid_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             accept;
    logic             step_err;
    codec_mode_e      in_mode_e;

    assign in_mode_e = codec_mode_e'(in_mode);
    assign accept    = in_valid && in_ready;

    // Step check against the last accepted Gray word. Binary words are
    // invisible to the history so they can be interleaved freely.
    always_comb begin
        hist_d       = hist_q;
        hist_valid_d = hist_valid_q;
        step_err     = 1'b0;
        if (in_mode_e == GRAY2BIN) begin
            step_err = in_valid && hist_valid_q &&
                       (popcount(MAX_W'(in_data ^ hist_q)) > 1);
            if (accept) begin
                hist_d       = in_data;
                hist_valid_d = 1'b1;
            end
        end
    end

    // Count flagged words when they leave, not when they enter, so dropped
    // (reset) words never count.
    always_comb begin
        err_count_d = err_count_q;
        if (out_valid && out_ready && out_step_err && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q       <= '0;
            hist_valid_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            hist_q       <= hist_d;
            hist_valid_q <= hist_valid_d;
            err_count_q  <= err_count_d;
        end
    end

    assign stg_valid[0] = in_valid;
    assign stg_word[0]  = in_data;
    assign stg_res[0]   = '0;
    assign stg_carry[0] = 1'b0;
    assign stg_mode[0]  = in_mode_e;
    assign stg_err[0]   = step_err;

    assign stg_ready[STAGES] = out_ready;
    assign in_ready          = stg_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        gray_codec_stage #(
            .WIDTH    (WIDTH),
            .STAGES   (STAGES),
            .STAGE_IDX(k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .up_valid(stg_valid[k]),
            .up_ready(stg_ready[k]),
            .up_word (stg_word[k]),
            .up_res  (stg_res[k]),
            .up_carry(stg_carry[k]),
            .up_mode (stg_mode[k]),
            .up_err  (stg_err[k]),
            .dn_ready(stg_ready[k+1]),
            .dn_valid(stg_valid[k+1]),
            .dn_word (stg_word[k+1]),
            .dn_res  (stg_res[k+1]),
            .dn_carry(stg_carry[k+1]),
            .dn_mode (stg_mode[k+1]),
            .dn_err  (stg_err[k+1])
        );
    end

    assign out_valid    = stg_valid[STAGES];
    assign out_data     = stg_res[STAGES];
    assign out_mode     = stg_mode[STAGES];
    assign out_step_err = stg_err[STAGES];
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_gray_pipe_codec.sv
// Self-checking bench for gray_pipe_codec.
// Three instances share the input stimulus and out_ready:
//   dut_a  WIDTH=8 STAGES=2 CNT_W=16  (fully scoreboarded)
//   dut_b  WIDTH=8 STAGES=1 CNT_W=2   (throughput, counter saturation)
//   dut_c  WIDTH=8 STAGES=8 CNT_W=16  (throughput)
module tb_gray_pipe_codec;

    typedef struct {
        logic [7:0] data;
        logic       mode;
        logic       err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_mode;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_mode_a, out_step_err_a;
    logic [7:0]  out_data_a;
    logic [15:0] err_count_a;
    logic        in_ready_b, out_valid_b, out_mode_b, out_step_err_b;
    logic [7:0]  out_data_b;
    logic [1:0]  err_count_b;
    logic        in_ready_c, out_valid_c, out_mode_c, out_step_err_c;
    logic [7:0]  out_data_c;
    logic [15:0] err_count_c;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];
    exp_t sb_head;
    int   del_a = 0;
    int   rx_b  = 0;
    int   rx_c  = 0;
    int   cyc   = 0;
    bit   mon_en = 0;

    gray_pipe_codec #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .out_mode(out_mode_a),
        .out_step_err(out_step_err_a), .err_count(err_count_a)
    );

    gray_pipe_codec #(.WIDTH(8), .STAGES(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .out_mode(out_mode_b),
        .out_step_err(out_step_err_b), .err_count(err_count_b)
    );

    gray_pipe_codec #(.WIDTH(8), .STAGES(8), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_c),
        .out_ready(out_ready), .out_data(out_data_c), .out_mode(out_mode_c),
        .out_step_err(out_step_err_c), .err_count(err_count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Scoreboard for dut_a: every delivered word must match the oldest expected one.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready) begin
            checkOutput("sb_nonempty", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                sb_head = sb.pop_front();
                checkOutput("sb_data", 32'(out_data_a), 32'(sb_head.data));
                checkOutput("sb_mode", 32'(out_mode_a), 32'(sb_head.mode));
                checkOutput("sb_err",  32'(out_step_err_a), 32'(sb_head.err));
            end
            del_a++;
        end
    end

    // Throughput monitors: word i of the stream is gray(i), so it must decode to i.
    always @(negedge clk) begin
        if (mon_en && !rst && out_valid_b && out_ready) begin
            checkOutput("thru_b_data", 32'(out_data_b), 32'(rx_b[7:0]));
            rx_b++;
        end
    end

    always @(negedge clk) begin
        if (mon_en && !rst && out_valid_c && out_ready) begin
            checkOutput("thru_c_data", 32'(out_data_c), 32'(rx_c[7:0]));
            rx_c++;
        end
    end

    // Presents one word until dut_a accepts it, then records its expected result.
    task automatic applyStimulus(input logic [7:0] data, input logic mode,
                                 input logic [7:0] exp_data, input logic exp_err);
        bit acc = 0;
        exp_t e;
        in_valid = 1'b1;
        in_data  = data;
        in_mode  = mode;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready_a;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (acc) begin
            e.data = exp_data;
            e.mode = mode;
            e.err  = exp_err;
            sb.push_back(e);
        end else begin
            checkOutput("accept_timeout", 32'(acc), 32'd1);
        end
    endtask

    task automatic applyReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic drainOutputs();
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int cyc_start;
        logic [7:0] k8;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_mode   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_out_data",  32'(out_data_a), 32'd0);
        checkOutput("rst_out_mode",  32'(out_mode_a), 32'd0);
        checkOutput("rst_step_err",  32'(out_step_err_a), 32'd0);
        checkOutput("rst_err_count", 32'(err_count_a), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_in_ready",  32'(in_ready_a), 32'd1);

        // Decode 0xCA -> 0x8C with two-cycle latency, first word never flags
        applyStimulus(8'hCA, 1'b0, 8'h8C, 1'b0);
        checkOutput("lat_early", 32'(out_valid_a), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_valid", 32'(out_valid_a), 32'd1);
        checkOutput("dec_data",  32'(out_data_a), 32'h8C);
        checkOutput("dec_err",   32'(out_step_err_a), 32'd0);
        drainOutputs();

        // Encode 0x8C -> 0xCA
        applyStimulus(8'h8C, 1'b1, 8'hCA, 1'b0);
        drainOutputs();

        // Step check with interleaved binary words that must not touch history
        applyReset();
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        applyStimulus(8'h01, 1'b0, 8'h01, 1'b0);
        applyStimulus(8'h01, 1'b0, 8'h01, 1'b0);
        applyStimulus(8'hFF, 1'b1, 8'h80, 1'b0);
        applyStimulus(8'h07, 1'b0, 8'h05, 1'b1);
        applyStimulus(8'hFF, 1'b1, 8'h80, 1'b0);
        applyStimulus(8'h05, 1'b0, 8'h06, 1'b0);
        drainOutputs();
        checkOutput("step_err_count", 32'(err_count_a), 32'd1);

        // Backpressure: two words fit, output holds the first word
        applyReset();
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(8'h01, 1'b1, 8'h01, 1'b0);
                applyStimulus(8'h02, 1'b1, 8'h03, 1'b0);
                applyStimulus(8'h03, 1'b1, 8'h02, 1'b0);
                applyStimulus(8'h04, 1'b1, 8'h06, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                checkOutput("bp_hold_early", 32'(out_data_a), 32'h01);
                repeat (2) @(posedge clk);
                #2;
                checkOutput("bp_accepts",   32'(sb.size()), 32'd2);
                checkOutput("bp_in_ready",  32'(in_ready_a), 32'd0);
                checkOutput("bp_out_valid", 32'(out_valid_a), 32'd1);
                checkOutput("bp_hold_late", 32'(out_data_a), 32'h01);
                out_ready = 1'b1;
            end
        join
        drainOutputs();

        // Throughput: 100 back-to-back Gray words for STAGES = 1, 2, 8
        applyReset();
        del_a  = 0;
        rx_b   = 0;
        rx_c   = 0;
        mon_en = 1'b1;
        cyc_start = cyc;
        for (int i = 0; i < 100; i++) begin
            k8 = 8'(i);
            applyStimulus(k8 ^ (k8 >> 1), 1'b0, k8, 1'b0);
        end
        checkOutput("thru_cycles", 32'(cyc - cyc_start), 32'd100);
        @(posedge clk);
        #1;
        checkOutput("thru_b_count", 32'(rx_b), 32'd100);
        @(posedge clk);
        #1;
        checkOutput("thru_a_count", 32'(del_a), 32'd100);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("thru_c_count", 32'(rx_c), 32'd100);
        mon_en = 1'b0;

        // Round trip over all 256 codes: encode, then decode the Gray codes back
        applyReset();
        for (int i = 0; i < 256; i++) begin
            k8 = 8'(i);
            applyStimulus(k8, 1'b1, k8 ^ (k8 >> 1), 1'b0);
        end
        for (int i = 0; i < 256; i++) begin
            k8 = 8'(i);
            applyStimulus(k8 ^ (k8 >> 1), 1'b0, k8, 1'b0);
        end
        drainOutputs();
        checkOutput("rt_err_count", 32'(err_count_a), 32'd0);

        // Saturation: five illegal steps, 2-bit counter stops at 3
        applyReset();
        applyStimulus(8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) applyStimulus(8'h03, 1'b0, 8'h02, 1'b1);
            else            applyStimulus(8'h00, 1'b0, 8'h00, 1'b1);
        end
        drainOutputs();
        checkOutput("sat_count_a", 32'(err_count_a), 32'd5);
        checkOutput("sat_count_b", 32'(err_count_b), 32'd3);

        // Mid-stream reset drops in-flight words and clears the history
        out_ready = 1'b0;
        applyStimulus(8'h03, 1'b0, 8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0, 8'h02, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_valid", 32'(out_valid_a), 32'd0);
        checkOutput("mid_rst_cnt_a", 32'(err_count_a), 32'd0);
        checkOutput("mid_rst_cnt_b", 32'(err_count_b), 32'd0);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        applyStimulus(8'h0C, 1'b0, 8'h08, 1'b0);
        drainOutputs();
        checkOutput("post_rst_count", 32'(err_count_a), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
